// File: rtl/lockstep_pair_bank.sv
// Bank of cross-coupled x/y register pairs with load, fault injection and mismatch tracking.
// Latency: one cycle from load/en/inject to x/y; mismatch is combinational, sticky/count one cycle later.
// No backpressure: every input is accepted on every rising edge; reset overrides all controls.
module lockstep_pair_bank #(
    parameter int WIDTH     = 1,
    parameter int CHANNELS  = 1,
    parameter int MODE      = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [CHANNELS-1:0]         en_i,
    input  logic [CHANNELS-1:0]         load_i,
    input  logic [CHANNELS*WIDTH-1:0]   load_val_i,
    input  logic [CHANNELS-1:0]         inject_i,
    input  logic                        clear_err_i,
    output logic [CHANNELS*WIDTH-1:0]   x_o,
    output logic [CHANNELS*WIDTH-1:0]   y_o,
    output logic [CHANNELS-1:0]         mismatch_o,
    output logic [CHANNELS-1:0]         err_sticky_o,
    output logic [ERR_CNT_W-1:0]        err_count_o
);

    logic [CHANNELS-1:0][WIDTH-1:0] x_q, x_d;
    logic [CHANNELS-1:0][WIDTH-1:0] y_q, y_d;
    logic [CHANNELS-1:0]            mismatch;
    logic [CHANNELS-1:0]            err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0]           err_count_q, err_count_d;
    logic                           any_mismatch;

    // Update function shared by both halves of a pair; MODE 1 wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] f_upd(input logic [WIDTH-1:0] v);
        if (MODE == 1) begin
            return v + WIDTH'(1'b1);
        end else begin
            return ~v;
        end
    endfunction

    // Per-channel next state: load beats en beats hold; inject only lands on an en update of y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load_i[i]) begin
                x_d[i] = load_val_i[i*WIDTH +: WIDTH];
                y_d[i] = load_val_i[i*WIDTH +: WIDTH];
            end else if (en_i[i]) begin
                x_d[i] = f_upd(y_q[i]);
                y_d[i] = f_upd(x_q[i]) ^ WIDTH'(inject_i[i]);
            end
        end
    end

    // Pair divergence is visible in the same cycle it exists in the registers.
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mismatch[i] = (x_q[i] != y_q[i]);
        end
    end

    assign any_mismatch = |mismatch;

    // Error bookkeeping: a clear still captures the current cycle's mismatch so nothing is lost.
    always_comb begin
        err_sticky_d = err_sticky_q | mismatch;
        err_count_d  = err_count_q;
        if (clear_err_i) begin
            err_sticky_d = mismatch;
            err_count_d  = ERR_CNT_W'(any_mismatch);
        end else if (any_mismatch && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1'b1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q          <= '0;
            y_q          <= '0;
            err_sticky_q <= '0;
            err_count_q  <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign mismatch_o   = mismatch;
    assign err_sticky_o = err_sticky_q;
    assign err_count_o  = err_count_q;

`ifdef FORMAL
    logic [CHANNELS-1:0] clean_q;
    logic                past_valid = 1'b0;

    always_ff @(posedge clk_i) begin
        past_valid <= 1'b1;
    end

    // A pair is clean from reset/load until an inject is actually accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clean_q <= '1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load_i[i]) begin
                    clean_q[i] <= 1'b1;
                end else if (en_i[i] && inject_i[i]) begin
                    clean_q[i] <= 1'b0;
                end
            end
        end
    end

    assume property (@(posedge clk_i) !past_valid |-> rst_i);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_clean_chk
        assert property (@(posedge clk_i) (past_valid && clean_q[g]) |-> (x_q[g] == y_q[g]));
    end

    assert property (@(posedge clk_i)
        (past_valid && !rst_i && !clear_err_i) |=> (err_count_q >= $past(err_count_q)));
`endif

endmodule

// File: doc/lockstep_pair_bank.md
Name: lockstep_pair_bank

Overview:
- Parametrised bank of CHANNELS cross-coupled register pairs (x, y), each WIDTH bits wide.
- Each pair updates from its partner in lockstep, so x==y is an invariant whenever the pair starts equal.
- Adds synchronous reset, per-channel load, a fault-injection port and mismatch detection with sticky per-channel flags plus a saturating error counter.
- Serves as the generalised FPV target for invariant and initial-state checks, with properties embedded under FORMAL.

Parameters:
- WIDTH, 1, bit width of each x/y register.
- CHANNELS, 1, number of independent pairs.
- MODE, 0, update function. 0 = complement swap: x<=~y, y<=~x. 1 = increment swap: x<=y+1, y<=x+1, modulo 2^WIDTH.
- ERR_CNT_W, 8, width of err_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  CHANNELS  per-channel update enable.
- load  in  CHANNELS  per-channel load strobe.
- load_val  in  CHANNELS*WIDTH  load data; channel i occupies bits [i*WIDTH +: WIDTH].
- inject  in  CHANNELS  fault injection; flips bit 0 of the next y value, qualified by en.
- clear_err  in  1  clears err_sticky and err_count.
- x  out  CHANNELS*WIDTH  x registers, packed as load_val.
- y  out  CHANNELS*WIDTH  y registers, packed as load_val.
- mismatch  out  CHANNELS  combinational: x[i] != y[i].
- err_sticky  out  CHANNELS  registered sticky mismatch flag.
- err_count  out  ERR_CNT_W  saturating count of cycles with any mismatch.

Behaviour:
- Reset: while rst=1 at a rising edge, all x=0, y=0, err_sticky=0, err_count=0. Reset overrides load, en, inject and clear_err.
- Per-channel priority, rst=0: load > en > hold.
  - load[i]=1: x[i]<=load_val[i], y[i]<=load_val[i]. inject[i] is ignored.
  - en[i]=1, load[i]=0: x[i]<=F(y[i]), y[i]<=F(x[i]) ^ {WIDTH-1 zeros, inject[i]}. F is set by MODE.
  - en[i]=0, load[i]=0: hold. inject[i] is ignored.
- Latency: one cycle from load, en or inject to the new x/y.
- Mismatch persistence: in both modes an unequal pair stays unequal under en. It recovers only by load or rst.
- Invariant: with no inject since the last rst or load, x[i]==y[i] on every cycle.
- err_sticky[i] <= err_sticky[i] | mismatch[i], sampled on the current cycle. Visible one cycle after mismatch rises.
- err_count increments by 1 per cycle in which |mismatch is 1. Saturates at 2^ERR_CNT_W-1 with no wrap.
- clear_err=1:
  - err_sticky[i] <= mismatch[i]; set wins over clear.
  - err_count <= (|mismatch) ? 1 : 0.
- Channels are fully independent except the shared err_count and clear_err.
- WIDTH=1, MODE=1: increment equals complement, so behaviour is identical to MODE=0.
- Formal block (`ifdef FORMAL`):
  - Per-channel clean flag. Set on rst or load[i]. Cleared on accepted inject, i.e. en[i] & ~load[i] & inject[i].
  - Assert clean[i] -> x[i]==y[i].
  - Assert err_count never decreases except on clear_err or rst.
  - Assume rst=1 in the first cycle. No initial-value assumptions on x/y beyond this.

Test Plan:
- Reset, WIDTH=4, CHANNELS=2, MODE=0: rst=1 for 2 cycles with load=2'b11, load_val=8'hA5 -> x=y=0, err_sticky=0, err_count=0.
- Load then run, MODE=0, ch0: load_val=4'h5, 1 cycle load, then en=1 for 3 cycles -> x=y sequence 5, A, 5, A. mismatch=0 and err_count=0 throughout.
- Increment mode, MODE=1, WIDTH=4: load 4'hE, en=1 for 3 cycles -> x=y sequence E, F, 0, 1. Shows wrap, no mismatch.
- Inject, MODE=0: ch1 loaded 4'h3, en=1 and inject=1 for one cycle:
  - x=C, y=D, mismatch[1]=1 that cycle; err_sticky[1]=1 one cycle later.
  - Further en keeps mismatch=1 and err_count increments each cycle.
  - load 4'h3 clears mismatch; err_sticky stays 1.
- Saturation and clear, ERR_CNT_W=2: hold a mismatch for 5 cycles -> err_count 1, 2, 3, 3, 3.
  - clear_err while mismatch persists -> err_count=1, err_sticky stays 1.
  - After reload, clear_err -> err_count=0, err_sticky=0.
- Priority: load=1, en=1, inject=1 on the same channel -> x=y=load_val, no mismatch. rst=1 with clear_err=0 mid-mismatch -> all outputs 0 next cycle.
